// File: rtl/multi_host_if.sv
// multi_host_if: parallel operand/product handshakes plus the A/B/O serial link.
// master modport is the host block; slave modport is the bus side and the serial multiplier.
// Widths follow OP_W; product is 2*OP_W bits.
interface multi_host_if #(
  parameter int OP_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              A;
  logic              B;
  logic              O;
  logic              out_valid;
  logic              out_ready;
  logic [2*OP_W-1:0] product;
  logic              mismatch;

  modport master (
    input  in_valid, op_a, op_b, O, out_ready,
    output in_ready, A, B, out_valid, product, mismatch
  );

  modport slave (
    output in_valid, op_a, op_b, O, out_ready,
    input  in_ready, A, B, out_valid, product, mismatch
  );
endinterface

// File: rtl/multi_host.sv
// multi_host: serializes op_a/op_b LSB-first onto A/B and collects the LSB-first product from O.
// Latency: RX_DLY+2*OP_W+1 cycles from accept edge to out_valid; one IDLE cycle between operations.
// Backpressure: in_ready only in IDLE (no queueing); out_valid/product held in DONE until out_ready.
// Optional self-check: define MULTI_HOST_CHECK_EN to compare the collected product with op_a*op_b.
module multi_host #(
  parameter int OP_W   = 4,
  parameter int RX_DLY = 8
) (
  input logic          CLK,
  input logic          RST,
  multi_host_if.master hif
);
  localparam int PW = 2 * OP_W;
  localparam int CW = $clog2(PW + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   bit_cnt;
  logic [4:0]      dly_cnt;
  logic [OP_W-1:0] a_sh;
  logic [OP_W-1:0] b_sh;
  logic [PW-2:0]   rx_buf;
  logic [PW-1:0]   rx_full;
  logic [PW-1:0]   prod_q;
  logic            send_last;
  logic            dly_last;
  logic            recv_last;

  // dly_cnt counts cycles from t0, so it also decides whether WAIT is skipped.
  assign send_last = (state == SEND) && (bit_cnt == CW'(OP_W - 1));
  assign dly_last  = (dly_cnt == 5'(RX_DLY - 1));
  assign recv_last = (state == RECV) && (bit_cnt == CW'(PW - 1));
  // Last product bit comes straight from O so the result lands on the DONE entry edge.
  assign rx_full   = {hif.O, rx_buf};

  // The operand shifters empty themselves after OP_W shifts, so A/B idle at 0 outside SEND.
  assign hif.A         = a_sh[0];
  assign hif.B         = b_sh[0];
  assign hif.in_ready  = (state == IDLE);
  assign hif.out_valid = (state == DONE);
  assign hif.product   = prod_q;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hif.in_valid)  state_nxt = SEND;
      SEND:    if (send_last)     state_nxt = dly_last ? RECV : WAIT;
      WAIT:    if (dly_last)      state_nxt = RECV;
      RECV:    if (recv_last)     state_nxt = DONE;
      DONE:    if (hif.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Operand shifting, bit/delay counting and product capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh    <= '0;
      b_sh    <= '0;
      bit_cnt <= '0;
      dly_cnt <= '0;
      rx_buf  <= '0;
      prod_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hif.in_valid) begin
            a_sh    <= hif.op_a;
            b_sh    <= hif.op_b;
            bit_cnt <= '0;
            dly_cnt <= '0;
          end
        end
        SEND: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          dly_cnt <= dly_cnt + 5'd1;
          bit_cnt <= send_last ? '0 : bit_cnt + 1'b1;
        end
        WAIT: begin
          dly_cnt <= dly_cnt + 5'd1;
          bit_cnt <= '0;
        end
        RECV: begin
          for (int k = 0; k < PW - 1; k++) begin
            if (bit_cnt == CW'(k)) rx_buf[k] <= hif.O;
          end
          bit_cnt <= bit_cnt + 1'b1;
          if (recv_last) prod_q <= rx_full;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTI_HOST_CHECK_EN
  logic [PW-1:0] exp_q;
  logic          mis_q;

  // Reference product taken at accept; any disagreement at DONE entry sets a sticky flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q <= '0;
      mis_q <= 1'b0;
    end else begin
      if (state == IDLE && hif.in_valid) exp_q <= PW'(hif.op_a) * PW'(hif.op_b);
      if (recv_last && (rx_full != exp_q)) mis_q <= 1'b1;
    end
  end

  assign hif.mismatch = mis_q;
`else
  assign hif.mismatch = 1'b0;
`endif
endmodule

// File: doc/multi_host.md
Name: multi_host

Overview:
- Host-side companion of the bit-serial multiplier: the other end of its A/B/O serial interface.
- Accepts parallel operands over a valid/ready handshake and serializes them LSB-first onto A/B.
- Deserializes the serial product returned on O and presents it in parallel over a valid/ready handshake.
- Sits between the system bus/register block and the serial multiplier core.

Parameters:
- OP_W, 4, operand width in bits; product width is 2*OP_W.
- RX_DLY, 8, cycles from driving operand bit 0 to sampling product bit 0 on O; legal range OP_W..31.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  host can accept operands (high only in IDLE).
- op_a  input  OP_W  operand A.
- op_b  input  OP_W  operand B.
- A  output  1  serial operand A to multiplier, LSB-first.
- B  output  1  serial operand B to multiplier, LSB-first.
- O  input  1  serial product from multiplier, LSB-first.
- out_valid  output  1  product valid; held until accepted.
- out_ready  input  1  consumer accepts product.
- product  output  2*OP_W  collected product.
- mismatch  output  1  sticky self-check flag (see Optional Feature).

Behaviour:
- Reset (async, any state): state=IDLE; A=0, B=0, in_ready=1, out_valid=0, product=0, mismatch=0; counters and shift registers cleared. An operation in flight is abandoned; no partial result is ever presented.
- FSM states: IDLE, SEND, WAIT, RECV, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, latch op_a/op_b and clear the bit counter, then go to SEND. Call the cycle after that edge t0.
- SEND: in cycle t0+i (i=0..OP_W-1), A=op_a[i] and B=op_b[i], both registered outputs. After i=OP_W-1: go to WAIT if RX_DLY>OP_W, otherwise go straight to RECV. A=B=0 whenever not in SEND.
- WAIT: idle for cycles t0+OP_W .. t0+RX_DLY-1, counted by a delay counter.
- RECV: at the rising edge ending cycle t0+RX_DLY+j, capture O into product-shift bit j, for j=0..2*OP_W-1. After the last bit, go to DONE.
- DONE: entered in cycle t0+RX_DLY+2*OP_W. out_valid=1 and product is stable. On an edge with out_ready=1: out_valid drops, go to IDLE, in_ready returns high the next cycle. out_valid may be asserted combinationally from the DONE state.
- Fixed latency: accept edge to out_valid = RX_DLY+2*OP_W+1 cycles (17 with defaults) with no backpressure.
- in_valid outside IDLE is ignored; no queueing. Operands are sampled only at the accept edge.
- Back-to-back: the earliest next accept is the cycle after the out_ready edge, so there is exactly one IDLE cycle between operations.
- Counters are sized for 2*OP_W and 31 with no wrap. The bit counter resets on every entry to SEND and to RECV.
- Arithmetic: product is unsigned, exactly 2*OP_W bits; no truncation.

Optional Feature:
- Macro MULTI_HOST_CHECK_EN.
- Defined: at accept, the block computes the unsigned product op_a*op_b internally. On entry to DONE, it compares that value with the collected product. If they differ, mismatch is set and stays set until RST.
- Not defined: no multiplier logic is built and mismatch is tied to 0. The port list is identical in both builds.

Test Plan:
- op_a=4, op_b=3, bench multiplier model with RX_DLY=8 -> A serial 0,0,1,0 and B serial 1,1,0,0 in t0..t0+3; out_valid in cycle t0+16; product=8'h0C; mismatch=0.
- op_a=15, op_b=15, out_ready held low for 5 cycles -> product=8'hE1 with out_valid held stable for all 5 cycles; one IDLE cycle after acceptance.
- Two back-to-back ops, 0x9*0x6 then 0x0*0xF -> 8'h36 then 8'h00; in_valid pulses while busy are ignored and in_ready stays 0.
- RST pulsed in cycle t0+10 of the op 7*5 -> immediate IDLE, out_valid never rises; the next op 2*2 returns 8'h04.
- With MULTI_HOST_CHECK_EN, model corrupts product bit 3 of 3*3 -> product=8'h01 and mismatch=1 sticky; a following clean op leaves mismatch=1 until reset.
- OP_W=8, RX_DLY=8 (no WAIT state), 200*100 -> product=16'h4E20, out_valid 25 cycles after the accept edge.
